// File: rtl/uart_arb_pkg.sv
// Shared types, defaults and helpers for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_BUSY_TIMEOUT = 64;

    // Width of a requester index; never zero so single-requester builds still elaborate.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after the pointer, wrapping.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W   = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_valid
);

    always_comb begin
        int unsigned      sum;
        logic [IDX_W-1:0] idx;
        winner_oh  = '0;
        winner_idx = '0;
        any_valid  = 1'b0;
        sum        = 0;
        idx        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // Pointer is always below NUM_REQ, so one subtraction handles the wrap.
            sum = i + 32'(pointer);
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDX_W'(sum);
            if (!any_valid && eligible[idx]) begin
                any_valid      = 1'b1;
                winner_idx     = idx;
                winner_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter via its tx_start/tx_busy handshake.
// Define UART_ARB_LOCK_EN to hold the grant for a multi-byte frame ended by req_last.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter  int unsigned DATA_W       = DEF_DATA_W,
    parameter  int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    localparam int unsigned IDX_W        = grant_w(NUM_REQ)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      arb_busy,
    output logic                      err_timeout,
    output logic [15:0]               byte_cnt
);

    localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [TMR_W-1:0]   busy_tmr_q;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   next_ptr;
    logic [DATA_W-1:0]  win_data;
    logic               any_valid;
    logic               accept;
    logic               timeout_hit;

    uart_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eligible   (eligible),
        .pointer    (rr_ptr_q),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .any_valid  (any_valid)
    );

    assign accept      = (state_q == StIdle) && !tx_busy && any_valid;
    assign req_ready   = ((state_q == StIdle) && !tx_busy) ? win_oh : '0;
    assign arb_busy    = (state_q != StIdle);
    assign timeout_hit = (state_q == StStart) && !tx_busy &&
                         (busy_tmr_q == TMR_W'(BUSY_TIMEOUT - 1));
    assign next_ptr    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic               lock_q;
    logic [IDX_W-1:0]   lock_id_q;
    logic [NUM_REQ-1:0] lock_mask;

    always_comb begin
        lock_mask            = '0;
        lock_mask[lock_id_q] = 1'b1;
    end

    assign eligible = lock_q ? (req_valid & lock_mask) : req_valid;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (accept) begin
            lock_q    <= ~req_last[win_idx];
            lock_id_q <= win_idx;
        end else if (timeout_hit) begin
            lock_q <= 1'b0;
        end
    end
`else
    logic unused_req_last;
    assign unused_req_last = ^req_last;
    assign eligible        = req_valid;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            busy_tmr_q  <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            byte_cnt    <= '0;
        end else begin
            err_timeout <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        tx_data    <= win_data;
                        grant_id   <= win_idx;
                        rr_ptr_q   <= next_ptr;
                        busy_tmr_q <= '0;
                        tx_start   <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        byte_cnt <= byte_cnt + 16'd1;
                        state_q  <= StWait;
                    end else if (timeout_hit) begin
                        // UART never acknowledged: drop the byte rather than stall everyone.
                        tx_start    <= 1'b0;
                        err_timeout <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        busy_tmr_q <= busy_tmr_q + TMR_W'(1);
                    end
                end
                StWait: begin
                    if (!tx_busy) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic         tx_start;
    logic [W-1:0] tx_data;
    logic         tx_busy;
    logic [1:0]   grant_id;
    logic         arb_busy;
    logic         err_timeout;
    logic [15:0]  byte_cnt;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_W       (W),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .err_timeout (err_timeout),
        .byte_cnt    (byte_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs
    logic [N-1:0] valid_drv = '0;
    logic [N-1:0] last_drv = '0;
    logic [W-1:0] data_drv [N];
    bit rst_drv = 1'b0;
    bit ext_busy = 1'b0;
    bit uart_mute = 1'b0;
    int busy_min = 1, busy_max = 8, delay_max = 0;

    // UART environment
    int u_busy_left = 0;
    int u_delay_left = 0;

    // Reference model: one byte in flight, acknowledged or not
    int m_ptr, m_age, m_cnt, m_gid, m_lock_id;
    bit m_flight, m_acked, m_err, m_lock;
    logic [W-1:0] m_data;

    int sent [N];
    int cyc = 0;
    bit prev_start = 1'b0;
    int start_cyc = -1;
    int err_cyc = -1;
    logic [N-1:0] obs_ready;
    int log_gid[$];
    logic [W-1:0] log_data[$];

    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < int'(N); k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_age = 0; m_cnt = 0; m_gid = 0; m_lock_id = 0;
        m_flight = 0; m_acked = 0; m_err = 0; m_lock = 0; m_data = '0;
    endtask

    task automatic step();
        logic [N-1:0] elig;
        logic [N-1:0] exp_ready;
        int w;
        @(negedge clk);
        cyc++;
        rst = rst_drv;
        for (int i = 0; i < int'(N); i++) req_data[i*W +: W] = data_drv[i];
        req_valid = valid_drv;
        req_last  = last_drv;
        if (u_busy_left > 0) begin
            tx_busy = 1'b1;
            u_busy_left--;
        end else if (tx_start && !uart_mute) begin
            if (u_delay_left > 0) begin
                u_delay_left--;
                tx_busy = ext_busy;
            end else begin
                tx_busy = 1'b1;
                u_busy_left = $urandom_range(busy_max, busy_min) - 1;
            end
        end else begin
            tx_busy = ext_busy;
        end
        #1;
        obs_ready = req_ready;
        if (tx_start && !prev_start) begin
            log_gid.push_back(int'(grant_id));
            log_data.push_back(tx_data);
            start_cyc = cyc;
        end
        prev_start = tx_start;
        if (err_timeout === 1'b1) err_cyc = cyc;

        elig = valid_drv;
`ifdef UART_ARB_LOCK_EN
        if (m_lock) elig = valid_drv & (N'(1) << m_lock_id);
`endif
        w = pick(elig, m_ptr);
        exp_ready = (!m_flight && !tx_busy && w >= 0) ? (N'(1) << w) : '0;

        check_eq("req_ready", req_ready, exp_ready);
        check_eq("ready_onehot", $onehot0(req_ready), 1);
        check_eq("tx_start", tx_start, m_flight && !m_acked);
        check_eq("arb_busy", arb_busy, m_flight);
        check_eq("tx_data", tx_data, m_data);
        check_eq("grant_id", grant_id, m_gid);
        check_eq("byte_cnt", byte_cnt, m_cnt);
        check_eq("err_timeout", err_timeout, m_err);

        if (rst_drv) begin
            model_reset();
        end else begin
            m_err = 0;
            if (!m_flight) begin
                if (exp_ready != '0) begin
                    m_flight = 1; m_acked = 0; m_age = 0;
                    m_data = data_drv[w]; m_gid = w; m_ptr = (w + 1) % N;
                    sent[w]++;
                    u_delay_left = $urandom_range(delay_max, 0);
`ifdef UART_ARB_LOCK_EN
                    if (last_drv[w]) m_lock = 0;
                    else begin m_lock = 1; m_lock_id = w; end
`endif
                end
            end else if (!m_acked) begin
                if (tx_busy) begin
                    m_acked = 1;
                    m_cnt = (m_cnt + 1) % 65536;
                end else begin
                    m_age++;
                    if (m_age == int'(TO)) begin
                        m_flight = 0; m_err = 1; m_lock = 0;
                    end
                end
            end else if (!tx_busy) begin
                m_flight = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        log_gid.delete();
        log_data.delete();
    endtask

    task automatic settle();
        valid_drv = '0;
        for (int k = 0; k < 300 && (m_flight || u_busy_left > 0); k++) step();
        check_eq("settle_bound", m_flight || u_busy_left > 0, 0);
        step();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit saw_ready;
        for (int i = 0; i < int'(N); i++) begin data_drv[i] = '0; sent[i] = 0; end
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0;
        model_reset();
        @(posedge clk);
        do_reset();
        check_eq("rst_tx_start", tx_start, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_arb_busy", arb_busy, 0);
        check_eq("rst_err", err_timeout, 0);
        check_eq("rst_byte_cnt", byte_cnt, 0);

        // Two steady requesters with a 20-cycle UART frame
        data_drv[0] = 8'h3D; data_drv[2] = 8'hAB;
        busy_min = 20; busy_max = 20; delay_max = 0;
        valid_drv = 4'b0101;
        for (int k = 0; k < 400 && log_gid.size() < 4; k++) step();
        valid_drv = '0;
        for (int k = 0; k < 40; k++) step();
        check_eq("alt_count", log_gid.size() >= 4, 1);
        if (log_gid.size() >= 4) begin
            check_eq("alt_gid0", log_gid[0], 0);  check_eq("alt_gid1", log_gid[1], 2);
            check_eq("alt_gid2", log_gid[2], 0);  check_eq("alt_gid3", log_gid[3], 2);
            check_eq("alt_dat0", log_data[0], 8'h3D); check_eq("alt_dat1", log_data[1], 8'hAB);
            check_eq("alt_dat2", log_data[2], 8'h3D); check_eq("alt_dat3", log_data[3], 8'hAB);
        end
        check_eq("alt_byte_cnt", byte_cnt, 4);

        // All four valid: strict rotation with wrap 3 -> 0
        do_reset();
        busy_min = 1; busy_max = 6; delay_max = 2;
        valid_drv = 4'b1111;
        for (int k = 0; k < 600 && log_gid.size() < 5; k++) begin
            for (int i = 0; i < int'(N); i++) data_drv[i] = W'($urandom);
            step();
        end
        check_eq("rot_count", log_gid.size() >= 5, 1);
        if (log_gid.size() >= 5) begin
            for (int i = 0; i < 5; i++) check_eq("rot_gid", log_gid[i], i % 4);
        end

        // UART never answers: timeout after exactly TO cycles in START
        do_reset();
        settle();
        uart_mute = 1'b1; err_cyc = -1; start_cyc = -1;
        valid_drv = 4'b0010;
        for (int k = 0; k < 50 && !m_flight; k++) step();
        valid_drv = '0;
        for (int k = 0; k < 200 && err_cyc < 0; k++) step();
        check_eq("to_seen", err_cyc >= 0, 1);
        check_eq("to_latency", err_cyc - start_cyc, TO);
        check_eq("to_arb_busy", arb_busy, 0);
        check_eq("to_byte_cnt", byte_cnt, 0);
        uart_mute = 1'b0;
        step();
        check_eq("to_pulse_one", err_timeout, 0);

        // Frame from requester 1 competing with requester 0
        do_reset();
        settle();
        busy_min = 1; busy_max = 5; delay_max = 1;
        valid_drv = 4'b0001;
        for (int k = 0; k < 50 && !m_flight; k++) step();
        settle();
        log_gid.delete(); log_data.delete();
        sent[0] = 0; sent[1] = 0;
        for (int k = 0; k < 400 && log_gid.size() < 4; k++) begin
            last_drv  = {2'b00, sent[1] == 2, 1'b0};
            valid_drv = {2'b00, sent[1] < 3, 1'b1};
            step();
        end
        valid_drv = '0; last_drv = '0;
        check_eq("frame_count", log_gid.size() >= 4, 1);
        if (log_gid.size() >= 4) begin
`ifdef UART_ARB_LOCK_EN
            check_eq("frame_g0", log_gid[0], 1); check_eq("frame_g1", log_gid[1], 1);
            check_eq("frame_g2", log_gid[2], 1); check_eq("frame_g3", log_gid[3], 0);
`else
            check_eq("frame_g0", log_gid[0], 1); check_eq("frame_g1", log_gid[1], 0);
            check_eq("frame_g2", log_gid[2], 1); check_eq("frame_g3", log_gid[3], 0);
`endif
        end

        // Reset while the UART is busy with a byte
        do_reset();
        settle();
        busy_min = 20; busy_max = 20; delay_max = 0;
        valid_drv = 4'b1111;
        for (int k = 0; k < 400 && !(m_cnt >= 2 && m_flight && m_acked); k++) step();
        check_eq("rw_reached_wait", m_cnt >= 2 && m_flight && m_acked, 1);
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rw_tx_start", tx_start, 0);
        check_eq("rw_arb_busy", arb_busy, 0);
        check_eq("rw_byte_cnt", byte_cnt, 0);
        log_gid.delete(); log_data.delete();
        for (int k = 0; k < 200 && log_gid.size() < 1; k++) step();
        check_eq("rw_regrant", log_gid.size() >= 1, 1);
        if (log_gid.size() >= 1) check_eq("rw_ptr_zero", log_gid[0], 0);

        // External busy blocks arbitration without an error
        do_reset();
        settle();
        busy_min = 1; busy_max = 4;
        ext_busy = 1'b1; valid_drv = 4'b1000; saw_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            saw_ready |= (obs_ready != '0);
        end
        check_eq("xb_no_ready", saw_ready, 0);
        check_eq("xb_no_err", err_timeout, 0);
        ext_busy = 1'b0;
        step();
        check_eq("xb_grant_next", obs_ready, 4'b1000);
        settle();

        // Random traffic
        busy_min = 1; busy_max = 12; delay_max = 3;
        for (int i = 0; i < int'(N); i++) sent[i] = 0;
        for (int k = 0; k < 3000; k++) begin
            valid_drv = N'($urandom);
            last_drv  = N'($urandom);
            for (int i = 0; i < int'(N); i++) data_drv[i] = W'($urandom);
            ext_busy = ($urandom_range(9, 0) == 0);
            step();
        end
        ext_busy = 1'b0;
        settle();
        check_eq("rand_progress", (sent[0] + sent[1] + sent[2] + sent[3]) > 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
